cpu_state_dumper: RTL and testbench

- Reader-side counterpart to the CPU state preload: on `start`, walks the register file, then a window of data memory.
- Streams each word out over a valid/ready channel, tagged with its source and index.
- Sits beside the pipelined CPU, attached to spare read ports on the ID register file and the MEM data memory.
- Lets a host or bench collect the full architectural state as a transaction stream.

---
 rtl/cpu_state_dumper.sv | 139 +++++++++++++
 tb/tb_cpu_state_dumper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: walks the register file and then a window of data memory
// and streams every word over a valid/ready channel.
// Each word is tagged with its source (out_sel) and its index (out_index).
// Both memories are read through combinational spare read ports.
// Every read address and every stream output comes straight from a register.
module cpu_state_dumper #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int DM_WORDS = 16,
    parameter int DM_AW    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [DM_AW-1:0]  dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    output logic [DM_AW-1:0]  out_index,
    output logic              out_last
);

    // The read pointer must hold both a register number and a DM word index.
    localparam int PW = (DM_AW > 5) ? DM_AW : 5;
    localparam logic [PW-1:0] REG_LAST = PW'(NUM_REGS - 1);
    localparam logic [PW-1:0] DM_LAST  = PW'(DM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REGS  = 3'd1,
        S_MEM   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_last;
    logic                r_sel;
    logic [DATA_W-1:0]   r_data;
    logic [DM_AW-1:0]    r_index;
    logic                w_slot_free;

    // The output slot can take a new word when it is empty or being drained now.
    assign w_slot_free = !r_valid || out_ready;

    assign busy      = r_busy;
    assign done      = r_done;
    assign reg_raddr = 5'(r_ptr);
    assign dm_raddr  = DM_AW'(r_ptr);
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_index = r_index;
    assign out_last  = r_last;

    // Dump sequencer: the FSM, the read pointer and the registered output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sel   <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_REGS;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_REGS: begin
                    if (w_slot_free) begin
                        r_data  <= reg_rdata;
                        r_sel   <= 1'b0;
                        r_index <= DM_AW'(r_ptr);
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        if (r_ptr == REG_LAST) begin
                            r_ptr   <= '0;
                            r_state <= S_MEM;
                        end else begin
                            r_ptr <= r_ptr + PW'(1);
                        end
                    end
                end
                S_MEM: begin
                    if (w_slot_free) begin
                        r_data  <= dm_rdata;
                        r_sel   <= 1'b1;
                        r_index <= DM_AW'(r_ptr);
                        r_valid <= 1'b1;
                        if (r_ptr == DM_LAST) begin
                            // Pointer parks on the final index; nothing more is read.
                            r_last  <= 1'b1;
                            r_state <= S_FLUSH;
                        end else begin
                            r_last <= 1'b0;
                            r_ptr  <= r_ptr + PW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // out_valid is always high here; wait for the last handshake.
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Self-checking bench for cpu_state_dumper.
// Instance A has 16 DM words and carries the main directed sequence.
// Instance B has 32 DM words and checks the wide-window boundary.
module tb_cpu_state_dumper;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_start, a_ready, a_busy, a_done, a_valid, a_sel, a_last;
    logic [4:0]  a_reg_raddr;
    logic [6:0]  a_dm_raddr, a_index;
    logic [31:0] a_reg_rdata, a_dm_rdata, a_data;

    logic        b_start, b_ready, b_busy, b_done, b_valid, b_sel, b_last;
    logic [4:0]  b_reg_raddr;
    logic [6:0]  b_dm_raddr, b_index;
    logic [31:0] b_reg_rdata, b_dm_rdata, b_data;

    logic [31:0] rf [0:31];
    logic [31:0] dm [0:127];

    logic [40:0] q [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign a_reg_rdata = rf[a_reg_raddr];
    assign a_dm_rdata  = dm[a_dm_raddr];
    assign b_reg_rdata = rf[b_reg_raddr];
    assign b_dm_rdata  = dm[b_dm_raddr];

    cpu_state_dumper #(.DATA_W(32), .NUM_REGS(32), .DM_WORDS(16), .DM_AW(7)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .reg_raddr(a_reg_raddr), .reg_rdata(a_reg_rdata),
        .dm_raddr(a_dm_raddr), .dm_rdata(a_dm_rdata),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_sel(a_sel), .out_index(a_index), .out_last(a_last)
    );

    cpu_state_dumper #(.DATA_W(32), .NUM_REGS(32), .DM_WORDS(32), .DM_AW(7)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .reg_raddr(b_reg_raddr), .reg_rdata(b_reg_rdata),
        .dm_raddr(b_dm_raddr), .dm_rdata(b_dm_rdata),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_sel(b_sel), .out_index(b_index), .out_last(b_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream {last, sel, index, data} for a 32-register / DMW-word dump.
    task automatic build_exp(input int dmw);
        q.delete();
        for (int r = 0; r < 32; r++) q.push_back({1'b0, 1'b0, 7'(r), rf[r]});
        for (int d = 0; d < dmw; d++) q.push_back({(d == dmw - 1), 1'b1, 7'(d), dm[d]});
    endtask

    task automatic chk_a_zero(input string nm);
        chk({nm, ":valid"}, a_valid, 64'd0);
        chk({nm, ":busy"}, a_busy, 64'd0);
        chk({nm, ":done"}, a_done, 64'd0);
        chk({nm, ":last"}, a_last, 64'd0);
        chk({nm, ":sel"}, a_sel, 64'd0);
        chk({nm, ":data"}, a_data, 64'd0);
        chk({nm, ":index"}, a_index, 64'd0);
        chk({nm, ":reg_raddr"}, a_reg_raddr, 64'd0);
        chk({nm, ":dm_raddr"}, a_dm_raddr, 64'd0);
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: ready 0 for 10 cycles.
    task automatic do_dump(input int mode, input bit mid_start, input bit do_reset, input string nm);
        logic [40:0] held, exp_w, obs_w;
        logic [40:0] got [48];
        bit          stall, finished;
        int          nrecv, last_cyc;
        stall = 1'b0; finished = 1'b0; nrecv = 0; last_cyc = -1; held = '0;
        for (int i = 0; i < 48; i++) got[i] = '0;
        build_exp(16);
        @(negedge clk); a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk({nm, ":busy_rise"}, a_busy, 64'd1);
        chk({nm, ":valid_not_yet"}, a_valid, 64'd0);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            case (mode)
                1:       a_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       a_ready = (cyc >= 10);
                default: a_ready = 1'b1;
            endcase
            obs_w = {a_last, a_sel, a_index, a_data};
            if (cyc == 0) chk({nm, ":first_latency"}, a_valid, 64'd1);
            if (mode == 2 && cyc < 10) begin
                chk({nm, ":hold_valid"}, a_valid, 64'd1);
                chk({nm, ":hold_index"}, a_index, 64'd0);
                chk({nm, ":hold_raddr"}, a_reg_raddr, 64'd1);
            end
            if (stall) chk({nm, ":stall_stable"}, obs_w, held);
            if (a_done) begin
                chk({nm, ":done_timing"}, last_cyc, cyc - 1);
                finished = 1'b1;
            end else if (do_reset && nrecv == 20 && a_valid) begin
                #1 rst = 1'b1;
                #1 chk_a_zero({nm, ":async_rst"});
                @(negedge clk); rst = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    chk({nm, ":post_rst_done"}, a_done, 64'd0);
                    chk({nm, ":post_rst_busy"}, a_busy, 64'd0);
                    chk({nm, ":post_rst_valid"}, a_valid, 64'd0);
                end
                q.delete();
                return;
            end else if (a_valid) begin
                chk({nm, ":busy_hi"}, a_busy, 64'd1);
                if (a_ready) begin
                    // An all-ones sentinel flags a word beyond the expected stream.
                    exp_w = (q.size() > 0) ? q.pop_front() : '1;
                    chk({nm, ":word"}, obs_w, exp_w);
                    if (nrecv < 48) got[nrecv] = obs_w;
                    nrecv++;
                    if (nrecv == 48) last_cyc = cyc;
                    stall = 1'b0;
                end else begin
                    held  = obs_w;
                    stall = 1'b1;
                end
            end else begin
                stall = 1'b0;
            end
            if (mid_start && nrecv == 10) a_start = 1'b1;
            else                          a_start = 1'b0;
        end
        a_start = 1'b0;
        chk({nm, ":done_seen"}, finished, 64'd1);
        chk({nm, ":count"}, nrecv, 64'd48);
        chk({nm, ":queue_empty"}, q.size(), 64'd0);
        if (mode == 0) begin
            chk({nm, ":no_gaps"}, last_cyc, 64'd47);
            chk({nm, ":xfer1"}, got[1], {1'b0, 1'b0, 7'd1, 32'h0000_0019});
            chk({nm, ":xfer32"}, got[32], {1'b0, 1'b1, 7'd0, 32'h0000_0009});
            chk({nm, ":xfer46_notlast"}, got[46][40], 64'd0);
            chk({nm, ":xfer47_last"}, got[47][40], 64'd1);
        end
        @(negedge clk);
        chk({nm, ":done_one_cycle"}, a_done, 64'd0);
        chk({nm, ":busy_low"}, a_busy, 64'd0);
        chk({nm, ":valid_low"}, a_valid, 64'd0);
    endtask

    initial begin
        int  cnt;
        bit  fin, seen30;
        rst = 1'b1; a_start = 1'b0; a_ready = 1'b0; b_start = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        for (int i = 0; i < 128; i++) dm[i] = 32'd0;
        rf[1] = 32'd25; rf[2] = 32'd25;
        dm[0] = 32'd9; dm[1] = 32'd3; dm[2] = 32'd15; dm[3] = 32'd2; dm[30] = 32'd254;

        // Reset state, while held and after release.
        repeat (3) @(negedge clk);
        chk_a_zero("rst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_a_zero("rst_released");

        // Wide window on instance B: DM[30] payload and out_last placement.
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        cnt = 0; fin = 1'b0; seen30 = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            if (b_valid) begin
                if (b_sel && b_index == 7'd30) begin
                    chk("b_dm30", b_data, 64'h0000_00FE);
                    seen30 = 1'b1;
                end
                chk("b_last_only_idx31", b_last, (b_sel && b_index == 7'd31));
                cnt++;
            end
            if (b_done) fin = 1'b1;
        end
        chk("b_done_seen", fin, 64'd1);
        chk("b_seen_idx30", seen30, 64'd1);
        chk("b_count", cnt, 64'd64);

        do_dump(0, 1'b0, 1'b0, "ready_high");
        do_dump(1, 1'b0, 1'b0, "ready_toggle");
        do_dump(0, 1'b0, 1'b1, "mid_reset");
        do_dump(0, 1'b0, 1'b0, "after_reset");
        do_dump(0, 1'b1, 1'b0, "start_while_busy");
        do_dump(2, 1'b0, 1'b0, "hold_ready_low");

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 16; i++) dm[i] = $urandom;
        do_dump(1, 1'b0, 1'b0, "random_toggle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
